cm_unsort: RTL and testbench
============================

// Module: cm_unsort
// PURPOSE
//  Inverse of cm_sort: scatters a sorted vector back to original positions.
//  o_data[i_idx[k]] = i_data[k], with i_idx[k] = original position of the k-th sorted element.
//  Sits downstream of cm_sort; restores order after per-rank processing.
//  Pipelined, no backpressure; flags invalid permutations.
// PARAMETERS
//  DCNT      4                 number of elements (>= 2)
//  DWIDTH    16                element width in bits
//  REG_CNT   1                 pipeline register stages (1..DCNT); equals latency
//  IDX_WIDTH sclog2(DCNT)      localparam, index width
// PORTS
//  i_clk   in   1                  clock
//  i_rst   in   1                  reset, asynchronous, active-high
//  i_vld   in   1                  input vector valid (single-cycle qualifier)
//  i_idx   in   DCNT*IDX_WIDTH     packed [DCNT-1:0][IDX_WIDTH-1:0], destination per sorted slot
//  i_data  in   DCNT*DWIDTH        packed [DCNT-1:0][DWIDTH-1:0], sorted data
//  o_vld   out  1                  output vector valid
//  o_data  out  DCNT*DWIDTH        data in original order
//  o_miss  out  DCNT               bit i set = no source element targeted position i
//  o_err   out  1                  permutation invalid: |o_miss, or any i_idx[k] >= DCNT
// BEHAVIOUR
//  - One clock (i_clk); reset asynchronous, active-high (i_rst).
//  - Reset: o_vld=0, o_data='0, o_miss='1, o_err=0; all pipeline regs cleared, incl. in-flight data.
//  - Latency: o_vld exactly REG_CNT cycles after i_vld. Output held until next o_vld.
//  - Throughput: 1 vector/cycle. Back-to-back i_vld allowed. No ready.
//  - Inputs sampled only when i_vld=1. Stage regs load only when their valid is set.
//  - Pipeline: G = ceil(DCNT/REG_CNT) sources per stage.
//    Stage s (0..REG_CNT-1) applies sources k in [s*G, min((s+1)*G, DCNT)).
//    Each stage carries: partial output vector, written bitmap, oor flag, remaining i_idx/i_data.
//    Stage 0 starts from partial='0, written='0, oor=0.
//    An empty last group (k >= DCNT) is a pure delay stage.
//  - Scatter rule: i_idx[k] < DCNT -> partial[i_idx[k]] = i_data[k]; written[i_idx[k]] = 1.
//    i_idx[k] >= DCNT -> element dropped, oor = 1.
//  - Duplicates: higher k wins (applied later, in-stage and across stages). Result is deterministic.
//  - Unwritten positions output '0. o_miss = ~written. o_err = (|o_miss) | oor.
//  - Reset mid-operation: all in-flight vectors discarded; no o_vld until a new i_vld after release.
//  - Combinational path per stage: G muxes x DCNT destinations. No comb path in->out.
// STRUCTURE
//  - cm_pkg: add function cm_unsort_grp(dcnt, reg_cnt) returning G.
//    Index width uses the existing sclog2.
//  - Sub-module cm_unsort_stage: params DCNT, DWIDTH, FIRST, LAST (source range).
//    Registers partial, written, oor, and pass-through idx/data.
//    Top instantiates REG_CNT of these in a generate chain and drives the outputs.
// TESTING (one instance per {DCNT,REG_CNT} in {4,1},{6,2},{8,3},{10,4}, DWIDTH=16)
//  1. DCNT=4,REG_CNT=1: idx={0,1,2,3} (k=3..0), data={40,30,20,10}
//     -> o_data={10,20,30,40}, o_err=0, o_vld 1 cycle after i_vld.
//  2. DCNT=10,REG_CNT=4: identity idx[k]=k, random data
//     -> o_data==i_data, o_miss=0, o_vld exactly 4 cycles after i_vld.
//  3. DCNT=4: idx[3:0]={3,2,1,1}, data={D,C,B,A}
//     -> o_data[1]=B, o_data[0]=0, o_miss=4'b0001, o_err=1.
//     DCNT=6 with idx[5]=7 -> o_err=1.
//  4. DCNT=8,REG_CNT=3: i_vld on 3 consecutive cycles, distinct permutations
//     -> 3 consecutive o_vld, each vector correct, no cross-vector mixing.
//  5. Reset mid-flight: DCNT=10,REG_CNT=4, i_rst for 1 cycle while 2 vectors in pipe
//     -> outputs at reset values immediately; no o_vld afterwards without new input.
//  6. Round trip: random data -> cm_sort -> cm_unsort (o_idx/o_data -> i_idx/i_data)
//     -> o_data equals original stimulus, o_err=0, for 20 random vectors per instance.

Source files
------------

// File: rtl/cm_unsort_pkg.sv
// Shared helpers for the cm_unsort scatter pipeline: index width and per-stage group size.
package cm_unsort_pkg;

  // Ceiling log2 with a floor of 1, so a 2-element vector still gets a 1-bit index.
  function automatic int unsigned sclog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Number of sources each pipeline stage applies.
  function automatic int unsigned cm_unsort_grp(input int unsigned dcnt, input int unsigned reg_cnt);
    return (dcnt + reg_cnt - 1) / reg_cnt;
  endfunction

endpackage

// File: rtl/cm_unsort_stage.sv
// One scatter stage: applies sources [FIRST, LAST) onto the partial vector and registers
// the result together with the untouched index/data vectors for the following stages.
module cm_unsort_stage
  import cm_unsort_pkg::*;
#(
  parameter int unsigned DCNT   = 4,
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned FIRST  = 0,
  parameter int unsigned LAST   = 4,
  localparam int unsigned IDX_WIDTH = sclog2(DCNT)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              vld_i,
  input  logic [DCNT-1:0][IDX_WIDTH-1:0]    idx_i,
  input  logic [DCNT-1:0][DWIDTH-1:0]       data_i,
  input  logic [DCNT-1:0][DWIDTH-1:0]       part_i,
  input  logic [DCNT-1:0]                   wr_i,
  input  logic                              oor_i,
  output logic                              vld_o,
  output logic [DCNT-1:0][IDX_WIDTH-1:0]    idx_o,
  output logic [DCNT-1:0][DWIDTH-1:0]       data_o,
  output logic [DCNT-1:0][DWIDTH-1:0]       part_o,
  output logic [DCNT-1:0]                   wr_o,
  output logic                              oor_o,
  output logic                              err_o
);

  logic                           vld_q;
  logic [DCNT-1:0][IDX_WIDTH-1:0] idx_q;
  logic [DCNT-1:0][DWIDTH-1:0]    data_q;
  logic [DCNT-1:0][DWIDTH-1:0]    part_q, part_d;
  logic [DCNT-1:0]                wr_q, wr_d;
  logic                           oor_q, oor_d;
  logic                           err_q, err_d;

  // Sources are applied in ascending k so a later duplicate overwrites an earlier one.
  always_comb begin
    part_d = part_i;
    wr_d   = wr_i;
    oor_d  = oor_i;
    for (int unsigned k = FIRST; k < LAST; k++) begin
      logic hit;
      hit = 1'b0;
      for (int unsigned j = 0; j < DCNT; j++) begin
        if (idx_i[k] == IDX_WIDTH'(j)) begin
          part_d[j] = data_i[k];
          wr_d[j]   = 1'b1;
          hit       = 1'b1;
        end
      end
      if (!hit) oor_d = 1'b1;
    end
    err_d = oor_d | ~(&wr_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
      part_q <= '0;
      wr_q   <= '0;
      oor_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        idx_q  <= idx_i;
        data_q <= data_i;
        part_q <= part_d;
        wr_q   <= wr_d;
        oor_q  <= oor_d;
        err_q  <= err_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign idx_o  = idx_q;
  assign data_o = data_q;
  assign part_o = part_q;
  assign wr_o   = wr_q;
  assign oor_o  = oor_q;
  assign err_o  = err_q;

endmodule

// File: rtl/cm_unsort.sv
// Scatters a sorted vector back to its original positions over REG_CNT pipeline stages
// and flags vectors whose index set is not a permutation.
module cm_unsort
  import cm_unsort_pkg::*;
#(
  parameter int unsigned DCNT    = 4,
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned REG_CNT = 1,
  localparam int unsigned IDX_WIDTH = sclog2(DCNT)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_vld,
  input  logic [DCNT-1:0][IDX_WIDTH-1:0] i_idx,
  input  logic [DCNT-1:0][DWIDTH-1:0]    i_data,
  output logic                           o_vld,
  output logic [DCNT-1:0][DWIDTH-1:0]    o_data,
  output logic [DCNT-1:0]                o_miss,
  output logic                           o_err
);

  localparam int unsigned G = cm_unsort_grp(DCNT, REG_CNT);

  logic                           vld_s  [REG_CNT+1];
  logic [DCNT-1:0][IDX_WIDTH-1:0] idx_s  [REG_CNT+1];
  logic [DCNT-1:0][DWIDTH-1:0]    data_s [REG_CNT+1];
  logic [DCNT-1:0][DWIDTH-1:0]    part_s [REG_CNT+1];
  logic [DCNT-1:0]                wr_s   [REG_CNT+1];
  logic                           oor_s  [REG_CNT+1];
  logic                           err_s  [REG_CNT];

  assign vld_s[0]  = i_vld;
  assign idx_s[0]  = i_idx;
  assign data_s[0] = i_data;
  assign part_s[0] = '0;
  assign wr_s[0]   = '0;
  assign oor_s[0]  = 1'b0;

  // Stages past the end of the source list get an empty range and act as pure delay.
  for (genvar s = 0; s < REG_CNT; s++) begin : g_stage
    localparam int unsigned FIRST = s * G;
    localparam int unsigned LAST  = ((s + 1) * G < DCNT) ? (s + 1) * G : DCNT;

    cm_unsort_stage #(
      .DCNT   (DCNT),
      .DWIDTH (DWIDTH),
      .FIRST  (FIRST),
      .LAST   (LAST)
    ) u_stage (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .vld_i  (vld_s[s]),
      .idx_i  (idx_s[s]),
      .data_i (data_s[s]),
      .part_i (part_s[s]),
      .wr_i   (wr_s[s]),
      .oor_i  (oor_s[s]),
      .vld_o  (vld_s[s+1]),
      .idx_o  (idx_s[s+1]),
      .data_o (data_s[s+1]),
      .part_o (part_s[s+1]),
      .wr_o   (wr_s[s+1]),
      .oor_o  (oor_s[s+1]),
      .err_o  (err_s[s])
    );
  end

  assign o_vld  = vld_s[REG_CNT];
  assign o_data = part_s[REG_CNT];
  assign o_miss = ~wr_s[REG_CNT];
  assign o_err  = err_s[REG_CNT-1];

endmodule

// File: tb/tb_cm_unsort.sv
// Directed bench for cm_unsort across four {DCNT, REG_CNT} configurations.
module tb_cm_unsort;
  import cm_unsort_pkg::*;

  localparam int NI   = 4;
  localparam int MAXD = 10;
  localparam int DC [NI] = '{4, 6, 8, 10};

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_t [NI];
  int          idx_t [MAXD];
  logic [15:0] dat_t [MAXD];
  logic [15:0] ex    [MAXD];

  logic [15:0]     od [NI][MAXD];
  logic [MAXD-1:0] om [NI];
  logic            oe [NI];
  logic            ov [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned D  = DC[g];
    localparam int unsigned IW = sclog2(D);
    logic [D-1:0][IW-1:0] idx;
    logic [D-1:0][15:0]   din, dout;
    logic [D-1:0]         miss;
    logic                 vo, eo;
    logic [15:0]          odl [MAXD];

    always_comb begin
      for (int k = 0; k < D; k++) begin
        idx[k] = IW'(idx_t[k]);
        din[k] = dat_t[k];
      end
    end

    always_comb begin
      for (int k = 0; k < MAXD; k++) odl[k] = '0;
      for (int k = 0; k < D; k++) odl[k] = dout[k];
    end

    cm_unsort #(.DCNT(D), .DWIDTH(16), .REG_CNT(g + 1)) u_dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_vld  (vld_t[g]),
      .i_idx  (idx),
      .i_data (din),
      .o_vld  (vo),
      .o_data (dout),
      .o_miss (miss),
      .o_err  (eo)
    );
  end

  always_comb begin
    for (int k = 0; k < MAXD; k++) begin
      od[0][k] = g_inst[0].odl[k];
      od[1][k] = g_inst[1].odl[k];
      od[2][k] = g_inst[2].odl[k];
      od[3][k] = g_inst[3].odl[k];
    end
    om[0] = 10'(g_inst[0].miss);
    om[1] = 10'(g_inst[1].miss);
    om[2] = 10'(g_inst[2].miss);
    om[3] = 10'(g_inst[3].miss);
    oe[0] = g_inst[0].eo;
    oe[1] = g_inst[1].eo;
    oe[2] = g_inst[2].eo;
    oe[3] = g_inst[3].eo;
    ov[0] = g_inst[0].vo;
    ov[1] = g_inst[1].vo;
    ov[2] = g_inst[2].vo;
    ov[3] = g_inst[3].vo;
  end

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] flat_obs(input int n);
    logic [159:0] f;
    f = '0;
    for (int j = 0; j < MAXD; j++) f[j*16 +: 16] = od[n][j];
    return f;
  endfunction

  function automatic logic [159:0] flat_exp();
    logic [159:0] f;
    f = '0;
    for (int j = 0; j < MAXD; j++) f[j*16 +: 16] = ex[j];
    return f;
  endfunction

  task automatic clr();
    for (int j = 0; j < MAXD; j++) begin
      ex[j]    = '0;
      idx_t[j] = 0;
      dat_t[j] = '0;
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int n = 0; n < NI; n++) begin
      chk_i({tag, "_vld"},  int'(ov[n]), 0);
      chk_v({tag, "_data"}, flat_obs(n), '0);
      chk_i({tag, "_miss"}, int'(om[n]), (1 << DC[n]) - 1);
      chk_i({tag, "_err"},  int'(oe[n]), 0);
    end
  endtask

  task automatic send(input int n);
    @(negedge clk);
    vld_t[n] = 1'b1;
    @(negedge clk);
    vld_t[n] = 1'b0;
  endtask

  // Called right after send(): counts cycles from the input pulse to o_vld.
  task automatic wait_out(input int n, input string tag);
    int cnt;
    cnt = 1;
    while (!ov[n] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk_i({tag, "_lat"}, cnt, n + 1);
  endtask

  task automatic chk_out(input string tag, input int n, input int miss_exp, input int err_exp);
    chk_v({tag, "_data"}, flat_obs(n), flat_exp());
    chk_i({tag, "_miss"}, int'(om[n]), miss_exp);
    chk_i({tag, "_err"},  int'(oe[n]), err_exp);
  endtask

  function automatic int p_idx(input int v, input int k);
    case (v)
      0:       return 7 - k;
      1:       return (k + 3) % 8;
      default: return k ^ 1;
    endcase
  endfunction

  // Source slot whose data lands on output position j for permutation v.
  function automatic int p_src(input int v, input int j);
    case (v)
      0:       return 7 - j;
      1:       return (j + 5) % 8;
      default: return j ^ 1;
    endcase
  endfunction

  task automatic round_trip(input int n);
    int          perm [MAXD];
    logic [15:0] orig [MAXD];
    int          r, t;
    for (int it = 0; it < 20; it++) begin
      clr();
      for (int k = 0; k < DC[n]; k++) begin
        perm[k] = k;
        orig[k] = 16'($urandom);
      end
      for (int k = DC[n] - 1; k > 0; k--) begin
        r = int'($urandom_range(k, 0));
        t = perm[k];
        perm[k] = perm[r];
        perm[r] = t;
      end
      for (int k = 0; k < DC[n]; k++) begin
        idx_t[k] = perm[k];
        dat_t[k] = orig[perm[k]];
        ex[k]    = orig[k];
      end
      send(n);
      wait_out(n, "t6");
      chk_out("t6", n, 0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    for (int n = 0; n < NI; n++) vld_t[n] = 1'b0;
    clr();
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;

    // Reverse permutation on the single-stage instance.
    clr();
    idx_t[0] = 3; idx_t[1] = 2; idx_t[2] = 1; idx_t[3] = 0;
    dat_t[0] = 16'd10; dat_t[1] = 16'd20; dat_t[2] = 16'd30; dat_t[3] = 16'd40;
    ex[0] = 16'd40; ex[1] = 16'd30; ex[2] = 16'd20; ex[3] = 16'd10;
    send(0);
    wait_out(0, "t1");
    chk_out("t1", 0, 0, 0);
    @(negedge clk);
    chk_i("t1_pulse", int'(ov[0]), 0);
    chk_v("t1_hold", flat_obs(0), flat_exp());

    // Identity on the four-stage instance.
    clr();
    for (int k = 0; k < 10; k++) begin
      idx_t[k] = k;
      dat_t[k] = 16'($urandom);
      ex[k]    = dat_t[k];
    end
    send(3);
    wait_out(3, "t2");
    chk_out("t2", 3, 0, 0);

    // In-stage duplicate: k=1 overwrites k=0 at position 1, position 0 unwritten.
    clr();
    idx_t[0] = 1; idx_t[1] = 1; idx_t[2] = 2; idx_t[3] = 3;
    dat_t[0] = 16'hA; dat_t[1] = 16'hB; dat_t[2] = 16'hC; dat_t[3] = 16'hD;
    ex[1] = 16'hB; ex[2] = 16'hC; ex[3] = 16'hD;
    send(0);
    wait_out(0, "t3a");
    chk_out("t3a", 0, 'h1, 1);

    // Out-of-range index on DCNT=6.
    clr();
    for (int k = 0; k < 6; k++) begin
      idx_t[k] = (k == 5) ? 7 : k;
      dat_t[k] = 16'(100 + k);
      ex[k]    = (k == 5) ? 16'd0 : 16'(100 + k);
    end
    send(1);
    wait_out(1, "t3b");
    chk_out("t3b", 1, 'h20, 1);

    // Cross-stage duplicate: k=5 in stage 1 overwrites k=0 from stage 0.
    clr();
    for (int k = 0; k < 6; k++) begin
      idx_t[k] = (k == 5) ? 0 : k;
      dat_t[k] = 16'(100 + k);
    end
    ex[0] = 16'd105; ex[1] = 16'd101; ex[2] = 16'd102; ex[3] = 16'd103; ex[4] = 16'd104;
    send(1);
    wait_out(1, "t3c");
    chk_out("t3c", 1, 'h20, 1);

    // Three back-to-back vectors through the three-stage instance.
    clr();
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        idx_t[k] = p_idx(v, k);
        dat_t[k] = 16'(v * 256 + k + 1);
      end
      vld_t[2] = 1'b1;
    end
    @(negedge clk);
    vld_t[2] = 1'b0;
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < 8; j++) ex[j] = 16'(v * 256 + p_src(v, j) + 1);
      chk_i("t4_vld", int'(ov[2]), 1);
      chk_out("t4", 2, 0, 0);
      @(negedge clk);
    end
    chk_i("t4_end", int'(ov[2]), 0);

    // Reset while two vectors are in flight.
    clr();
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        idx_t[k] = 9 - k;
        dat_t[k] = 16'(16'h5000 + v * 16 + k);
      end
      vld_t[3] = 1'b1;
    end
    @(negedge clk);
    vld_t[3] = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov[3]) cnt++;
    end
    chk_i("t5_novld", cnt, 0);
    chk_v("t5_data", flat_obs(3), '0);

    for (int n = 0; n < NI; n++) round_trip(n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
